// File: rtl/ext_bus_pkg.sv
// ext_bus_pkg
// Shared types and constants for the external bus arbiter.
//   state_e         : arbiter FSM states (IDLE -> ACCESS -> ACK)
//   IO_BASE_DEFAULT : default start of the IO region; lower addresses are RAM
//   WAIT_CW         : width of the per-access wait-state down counter
//   idx_width()     : bits needed to hold a requester index
package ext_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_e;

    localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;
    localparam int unsigned WAIT_CW         = 3;

    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ext_bus_pick.sv
// ext_bus_pick
// Combinational winner selection among pending requesters.
// Build option ARB_ROUND_ROBIN_EN:
//   defined   : round-robin, search begins at i_ptr and wraps modulo NREQ
//   undefined : fixed priority, lowest index wins; no pointer input exists
// Ports:
//   i_req     : per-requester request bits
//   i_ptr     : round-robin search start (round-robin build only)
//   o_win_oh  : one-hot winner (all zero when no request)
//   o_win_idx : binary index of the winner (0 when no request)
module ext_bus_pick
    import ext_bus_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = 1
) (
    input  logic [NREQ-1:0] i_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic [IW-1:0]   i_ptr,
`endif
    output logic [NREQ-1:0] o_win_oh,
    output logic [IW-1:0]   o_win_idx
);

`ifdef ARB_ROUND_ROBIN_EN
    int unsigned w_j;

    // Walk the search order backwards so the candidate closest to i_ptr is written last.
    always_comb begin
        o_win_oh  = '0;
        o_win_idx = '0;
        w_j       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = (int unsigned'(i_ptr) + int unsigned'(k)) % NREQ;
            if (i_req[w_j]) begin
                o_win_oh      = '0;
                o_win_oh[w_j] = 1'b1;
                o_win_idx     = IW'(w_j);
            end
        end
    end
`else
    // Descending walk leaves the lowest requesting index as the final winner.
    always_comb begin
        o_win_oh  = '0;
        o_win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                o_win_oh    = '0;
                o_win_oh[k] = 1'b1;
                o_win_idx   = IW'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/ext_bus_arbiter.sv
// ext_bus_arbiter
// Shares the external memory/IO bus among NREQ masters (requester 0 is the CPU core).
// Arbitrates, decodes the latched address into RAM/IO, runs a WAIT_CYCLES+1 cycle access
// and returns a single-cycle ack to the owner.
// Build option ARB_ROUND_ROBIN_EN: round-robin arbitration when defined, otherwise fixed
// priority with the lowest index first.
// Ports:
//   i_clk, i_reset           : clock, synchronous active-high reset
//   i_req, i_req_we          : per-requester request and write flag
//   i_req_addr, i_req_wdata  : packed per-requester address / write data
//   o_gnt                    : one-hot bus owner, held through ACCESS and ACK
//   o_ack                    : one-cycle completion pulse to the owner
//   o_rdata                  : read data, updated at each read completion
//   o_dir_mem_ex             : external address (ACCESS only)
//   o_write_ext, o_read_ext  : IO write / read strobes
//   o_we_ram                 : RAM write enable
//   o_bus_wdata, i_bus_rdata : bus write / read data
module ext_bus_arbiter
    import ext_bus_pkg::*;
#(
    parameter int unsigned   NREQ        = 2,
    parameter int unsigned   AW          = 16,
    parameter int unsigned   DW          = 16,
    parameter int unsigned   WAIT_CYCLES = 1,
    parameter logic [AW-1:0] IO_BASE     = AW'(IO_BASE_DEFAULT)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ-1:0]    i_req_we,
    input  logic [NREQ*AW-1:0] i_req_addr,
    input  logic [NREQ*DW-1:0] i_req_wdata,
    output logic [NREQ-1:0]    o_gnt,
    output logic [NREQ-1:0]    o_ack,
    output logic [DW-1:0]      o_rdata,
    output logic [AW-1:0]      o_dir_mem_ex,
    output logic               o_write_ext,
    output logic               o_read_ext,
    output logic               o_we_ram,
    output logic [DW-1:0]      o_bus_wdata,
    input  logic [DW-1:0]      i_bus_rdata
);

    localparam int unsigned IW = idx_width(NREQ);

    state_e               r_state;
    state_e               w_state_next;
    logic [NREQ-1:0]      r_gnt;
    logic [AW-1:0]        r_addr;
    logic                 r_we;
    logic [DW-1:0]        r_wdata;
    logic [DW-1:0]        r_rdata;
    logic [WAIT_CW-1:0]   r_wait;

    logic [NREQ-1:0]      w_win_oh;
    logic [IW-1:0]        w_win_idx;
    logic [AW-1:0]        w_sel_addr;
    logic [DW-1:0]        w_sel_wdata;
    logic                 w_sel_we;
    logic                 w_is_io;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0]        r_ptr;
`endif

    ext_bus_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_req     (i_req),
`ifdef ARB_ROUND_ROBIN_EN
        .i_ptr     (r_ptr),
`endif
        .o_win_oh  (w_win_oh),
        .o_win_idx (w_win_idx)
    );

    // Route the winner's request fields to the grant latches.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win_idx == IW'(i)) begin
                w_sel_addr  = i_req_addr[i*AW +: AW];
                w_sel_wdata = i_req_wdata[i*DW +: DW];
                w_sel_we    = i_req_we[i];
            end
        end
    end

    assign w_is_io     = (r_addr >= IO_BASE);
    assign o_gnt       = r_gnt;
    assign o_rdata     = r_rdata;
    assign o_bus_wdata = r_wdata;

    always_comb begin
        w_state_next = r_state;
        o_ack        = '0;
        o_dir_mem_ex = '0;
        o_we_ram     = 1'b0;
        o_write_ext  = 1'b0;
        o_read_ext   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (|i_req) begin
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                o_dir_mem_ex = r_addr;
                o_we_ram     = r_we & ~w_is_io;
                o_write_ext  = r_we & w_is_io;
                o_read_ext   = ~r_we & w_is_io;
                if (r_wait == '0) begin
                    w_state_next = ACK;
                end
            end
            ACK: begin
                o_ack        = r_gnt;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_wait  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr   <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            unique case (r_state)
                IDLE: begin
                    if (|i_req) begin
                        r_gnt   <= w_win_oh;
                        r_addr  <= w_sel_addr;
                        r_we    <= w_sel_we;
                        r_wdata <= w_sel_wdata;
                        r_wait  <= WAIT_CW'(WAIT_CYCLES);
`ifdef ARB_ROUND_ROBIN_EN
                        r_ptr   <= (w_win_idx == IW'(NREQ - 1)) ? '0 : w_win_idx + 1'b1;
`endif
                    end
                end
                ACCESS: begin
                    if (r_wait == '0) begin
                        // Writes leave the last read value visible.
                        if (!r_we) begin
                            r_rdata <= i_bus_rdata;
                        end
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                ACK: begin
                    r_gnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
